// File: rtl/node_stream_out.sv
// node_stream_out: snapshots all node positions on request, then streams
// them one per beat as clamped integer pixel coordinates (valid/ready).
//
// Ports:
//   clk, reset (sync, active-low)
//   snap_req           : capture request, honoured only while idle
//   nodes_x, nodes_y   : packed signed Q16.16 positions, node i at [32i+:32]
//   out_valid/out_ready: beat handshake
//   out_x, out_y       : clamped pixel coordinates of the presented node
//   out_idx, out_last  : node index, high on node NODES-1
//   out_clip           : x or y of the presented node was clamped
//   busy               : a frame is being streamed
//   drop_cnt           : saturating count of ignored snap_req
module node_stream_out #(
    parameter int NODES     = 20,
    parameter int FRAC_BITS = 16,
    parameter int X_MAX     = 639,
    parameter int Y_MAX     = 479
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  snap_req,
    input  logic [NODES*32-1:0]   nodes_x,
    input  logic [NODES*32-1:0]   nodes_y,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [15:0]           out_x,
    output logic [15:0]           out_y,
    output logic [7:0]            out_idx,
    output logic                  out_last,
    output logic                  out_clip,
    output logic                  busy,
    output logic [7:0]            drop_cnt
);

    localparam int IW = (NODES > 1) ? $clog2(NODES) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NODES - 1);

    typedef enum logic {
        S_IDLE,
        S_STREAM
    } state_t;

    state_t        state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [7:0]    drop_q, drop_d;
    logic          capture;

    logic [31:0]   shx_q [NODES];
    logic [31:0]   shy_q [NODES];

    // Floor to integer (arithmetic shift), then clamp to [0, maxv].
    // Result bit 16 flags that the clamp fired.
    function automatic logic [16:0] conv(
        input logic [31:0] raw,
        input logic [15:0] maxv
    );
        logic signed [31:0] v;
        v = $signed(raw) >>> FRAC_BITS;
        if (v < 0) begin
            conv = {1'b1, 16'd0};
        end else if (v > $signed({16'd0, maxv})) begin
            conv = {1'b1, maxv};
        end else begin
            conv = {1'b0, v[15:0]};
        end
    endfunction

    // Next-state logic
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        drop_d  = drop_q;
        capture = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (snap_req) begin
                    capture = 1'b1;
                    idx_d   = '0;
                    state_d = S_STREAM;
                end
            end
            S_STREAM: begin
                // A request during a frame, even on its last beat, is lost.
                if (snap_req && drop_q != 8'hFF) begin
                    drop_d = drop_q + 8'd1;
                end
                if (out_ready) begin
                    if (idx_q == LAST_IDX) begin
                        idx_d   = '0;
                        state_d = S_IDLE;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
        endcase
    end

    // State, counters and shadow registers
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            drop_q  <= '0;
            for (int i = 0; i < NODES; i++) begin
                shx_q[i] <= '0;
                shy_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            drop_q  <= drop_d;
            if (capture) begin
                for (int i = 0; i < NODES; i++) begin
                    shx_q[i] <= nodes_x[i*32 +: 32];
                    shy_q[i] <= nodes_y[i*32 +: 32];
                end
            end
        end
    end

    // Output mux/clamp: purely a function of registered state, so no
    // path exists from out_ready to the data outputs.
    logic [16:0] cx, cy;

    always_comb begin
        cx = conv(shx_q[idx_q], 16'(X_MAX));
        cy = conv(shy_q[idx_q], 16'(Y_MAX));
    end

    assign out_x     = cx[15:0];
    assign out_y     = cy[15:0];
    assign out_clip  = cx[16] | cy[16];
    assign out_idx   = 8'(idx_q);
    assign out_valid = (state_q == S_STREAM);
    assign busy      = (state_q == S_STREAM);
    assign out_last  = (state_q == S_STREAM) && (idx_q == LAST_IDX);
    assign drop_cnt  = drop_q;

endmodule

// File: tb/tb_node_stream_out.sv
// Scoreboard bench for node_stream_out: a frame-level model queues the
// expected beats at capture, a negedge monitor pops and compares them.
module tb_node_stream_out;

    localparam int NODES = 20;
    localparam int XMAX  = 639;
    localparam int YMAX  = 479;

    logic                clk = 1'b0;
    logic                reset;
    logic                snap_req;
    logic [NODES*32-1:0] nodes_x;
    logic [NODES*32-1:0] nodes_y;
    logic                out_valid;
    logic                out_ready;
    logic [15:0]         out_x;
    logic [15:0]         out_y;
    logic [7:0]          out_idx;
    logic                out_last;
    logic                out_clip;
    logic                busy;
    logic [7:0]          drop_cnt;

    node_stream_out dut (
        .clk      (clk),
        .reset    (reset),
        .snap_req (snap_req),
        .nodes_x  (nodes_x),
        .nodes_y  (nodes_y),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_x    (out_x),
        .out_y    (out_y),
        .out_idx  (out_idx),
        .out_last (out_last),
        .out_clip (out_clip),
        .busy     (busy),
        .drop_cnt (drop_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        int x;
        int y;
        int idx;
        bit last;
        bit clip;
    } beat_t;

    beat_t exp_q[$];
    int    n_cmp      = 0;
    int    n_bad      = 0;
    int    model_left = 0;
    int    exp_drop   = 0;
    bit    rst_edge   = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Real-valued floor of a Q16.16 number, then clamp.
    function automatic void ref_conv(input logic [31:0] raw, input int maxv,
                                     output int v, output bit clip);
        real r;
        int  fl;
        r  = $itor($signed(raw)) / 65536.0;
        fl = int'($floor(r));
        if (fl < 0) begin
            v = 0; clip = 1'b1;
        end else if (fl > maxv) begin
            v = maxv; clip = 1'b1;
        end else begin
            v = fl; clip = 1'b0;
        end
    endfunction

    // Frame-level model: beats remaining in the current frame.
    always @(posedge clk) begin
        if (!reset) begin
            model_left = 0;
            exp_drop   = 0;
            rst_edge   = 1'b1;
            exp_q.delete();
        end else begin
            rst_edge = 1'b0;
            if (model_left > 0) begin
                if (snap_req && exp_drop < 255) exp_drop++;
                if (out_ready) model_left--;
            end else if (snap_req) begin
                for (int i = 0; i < NODES; i++) begin
                    beat_t b;
                    bit cxb, cyb;
                    ref_conv(nodes_x[i*32 +: 32], XMAX, b.x, cxb);
                    ref_conv(nodes_y[i*32 +: 32], YMAX, b.y, cyb);
                    b.clip = cxb | cyb;
                    b.idx  = i;
                    b.last = (i == NODES - 1);
                    exp_q.push_back(b);
                end
                model_left = NODES;
            end
        end
    end

    // Monitor
    bit          prev_stall = 1'b0;
    logic [15:0] px, py;
    logic [7:0]  pidx;
    logic        plast, pclip;

    always @(negedge clk) begin
        check("valid", int'(out_valid), int'(model_left > 0));
        check("busy", int'(busy), int'(model_left > 0));
        check("drop_cnt", int'(drop_cnt), exp_drop);
        if (prev_stall && !rst_edge) begin
            check("hold_valid", int'(out_valid), 1);
            check("hold_x", int'(out_x), int'(px));
            check("hold_y", int'(out_y), int'(py));
            check("hold_idx", int'(out_idx), int'(pidx));
            check("hold_last", int'(out_last), int'(plast));
            check("hold_clip", int'(out_clip), int'(pclip));
        end
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_beat", 1, 0);
            end else begin
                beat_t e;
                e = exp_q.pop_front();
                check("out_x", int'(out_x), e.x);
                check("out_y", int'(out_y), e.y);
                check("out_idx", int'(out_idx), e.idx);
                check("out_last", int'(out_last), int'(e.last));
                check("out_clip", int'(out_clip), int'(e.clip));
            end
        end
        prev_stall = out_valid && !out_ready;
        px = out_x; py = out_y; pidx = out_idx;
        plast = out_last; pclip = out_clip;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_node(input int i, input logic [31:0] x, input logic [31:0] y);
        nodes_x[i*32 +: 32] = x;
        nodes_y[i*32 +: 32] = y;
    endtask

    function automatic logic [31:0] rnd_q(input int lo, input int hi);
        int xi;
        xi = int'($urandom_range(0, hi - lo)) + lo;
        return 32'(xi * 65536) + 32'($urandom_range(0, 65535));
    endfunction

    task automatic rand_nodes();
        for (int i = 0; i < NODES; i++) begin
            set_node(i, rnd_q(-50, 700), rnd_q(-50, 540));
        end
    endtask

    task automatic pulse_snap();
        snap_req = 1'b1;
        tick();
        snap_req = 1'b0;
    endtask

    // Run until the model frame drains; optional random ready / node churn.
    task automatic run_frame(input bit rnd_ready, input bit churn);
        int budget;
        budget = 2000;
        while (model_left > 0 && budget > 0) begin
            if (rnd_ready) out_ready = 1'($urandom_range(0, 1));
            if (churn) rand_nodes();
            tick();
            budget--;
        end
        if (budget == 0) check("frame_timeout", 1, 0);
        out_ready = 1'b1;
    endtask

    initial begin
        int budget;
        reset     = 1'b0;
        snap_req  = 1'b0;
        out_ready = 1'b0;
        nodes_x   = '0;
        nodes_y   = '0;
        repeat (3) tick();
        check("rst_valid", int'(out_valid), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_idx", int'(out_idx), 0);
        check("rst_x", int'(out_x), 0);
        check("rst_y", int'(out_y), 0);
        check("rst_clip", int'(out_clip), 0);
        check("rst_last", int'(out_last), 0);
        check("rst_drop", int'(drop_cnt), 0);
        reset = 1'b1;
        tick();

        // Basic frame with snapshot isolation (nodes churn after capture)
        for (int i = 0; i < NODES; i++) begin
            set_node(i, 32'(i * 688128), 32'(i * 278528));
        end
        out_ready = 1'b1;
        pulse_snap();
        check("first_idx", int'(out_idx), 0);
        run_frame(1'b0, 1'b1);
        tick();

        // Backpressure
        rand_nodes();
        pulse_snap();
        run_frame(1'b1, 1'b1);
        tick();

        // Clamp corners
        rand_nodes();
        set_node(0, 32'hFFFF8000, 32'(700 * 65536));
        set_node(1, 32'(639 * 65536 + 64880), 32'(479 * 65536 + 64880));
        set_node(2, 32'(640 * 65536), 32'hFFFF0000);
        set_node(3, 32'h0, 32'(480 * 65536));
        pulse_snap();
        run_frame(1'b0, 1'b0);
        tick();

        // Drops: three mid-frame, one on the last handshake, then M+1 accepted
        rand_nodes();
        pulse_snap();
        repeat (2) tick();
        for (int k = 0; k < 3; k++) begin
            pulse_snap();
            tick();
        end
        budget = 100;
        while (model_left != 1 && budget > 0) begin
            tick();
            budget--;
        end
        if (budget == 0) check("last_wait_timeout", 1, 0);
        snap_req = 1'b1;
        tick();
        check("drop4", int'(drop_cnt), 4);
        check("idle_after_last", int'(out_valid), 0);
        tick();
        snap_req = 1'b0;
        check("restart_valid", int'(out_valid), 1);
        check("restart_idx", int'(out_idx), 0);
        run_frame(1'b0, 1'b1);
        tick();

        // Saturation
        out_ready = 1'b0;
        pulse_snap();
        snap_req = 1'b1;
        repeat (300) tick();
        snap_req = 1'b0;
        check("drop_sat", int'(drop_cnt), 255);
        out_ready = 1'b1;
        run_frame(1'b0, 1'b0);
        tick();

        // Reset mid-stream at idx 7
        rand_nodes();
        pulse_snap();
        budget = 100;
        while (model_left != NODES - 7 && budget > 0) begin
            tick();
            budget--;
        end
        if (budget == 0) check("idx7_timeout", 1, 0);
        check("pre_rst_idx", int'(out_idx), 7);
        reset = 1'b0;
        tick();
        check("mid_rst_valid", int'(out_valid), 0);
        check("mid_rst_idx", int'(out_idx), 0);
        check("mid_rst_drop", int'(drop_cnt), 0);
        check("mid_rst_x", int'(out_x), 0);
        reset = 1'b1;
        tick();
        rand_nodes();
        pulse_snap();
        check("post_rst_idx", int'(out_idx), 0);
        run_frame(1'b0, 1'b0);
        tick();

        // Random traffic
        for (int c = 0; c < 400; c++) begin
            rand_nodes();
            snap_req  = ($urandom_range(0, 9) == 0);
            out_ready = 1'($urandom_range(0, 1));
            tick();
        end
        snap_req = 1'b0;
        run_frame(1'b0, 1'b0);
        repeat (2) tick();

        check("drain", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
